// File: rtl/ctrl_shadow_pkg.sv
// Shared types for the shadowed control register write path.
// Storage check option is selected in the top by CTRL_SHADOW_STORAGE_CHK_EN.
package ctrl_shadow_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_SLOW    = 2'b01,
        MODE_FAST    = 2'b10,
        MODE_DEFAULT = 2'b11
    } ctrl_mode_e;

    typedef struct packed {
        ctrl_mode_e  mode;
        logic [2:0]  cnt;
    } ctrl_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STAGED = 2'b01,
        COMMIT = 2'b10
    } ctrl_shadow_state_e;

    localparam ctrl_t CTRL_RESVAL = '{mode: MODE_DEFAULT, cnt: 3'b000};

    localparam int unsigned CTRL_TIMER_W = 8;

endpackage

// File: rtl/ctrl_shadow_timer.sv
// Saturating phase timer with clear/enable and an expiry flag.
module ctrl_shadow_timer
    import ctrl_shadow_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CTRL_TIMER_W-1:0] LAST =
        CTRL_TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CTRL_TIMER_W-1:0] MAX = '1;

    logic [CTRL_TIMER_W-1:0] cnt_q;
    logic [CTRL_TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/ctrl_shadow_wr.sv
// Two-phase staged/commit write controller for a shadowed control register.
// Define CTRL_SHADOW_STORAGE_CHK_EN to keep an inverted copy and flag corruption.
module ctrl_shadow_wr
    import ctrl_shadow_pkg::*;
#(
    parameter ctrl_t       RESVAL         = CTRL_RESVAL,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       we_i,
    input  logic [4:0] wd_i,
    input  logic       re_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic [4:0] qs_o,
    output logic [4:0] q_o,
    output logic       update_err_o,
    output logic       storage_err_o
);

    ctrl_shadow_state_e state_q, state_d;
    ctrl_t              staged_q, staged_d;
    ctrl_t              q_q, q_d;
    logic               uerr_q, uerr_d;
    logic               expired;

    ctrl_shadow_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (state_q != STAGED),
        .en_i     (state_q == STAGED),
        .expired_o(expired)
    );

    always_comb begin
        state_d  = state_q;
        staged_d = staged_q;
        q_d      = q_q;
        uerr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (we_i) begin
                    staged_d = ctrl_t'(wd_i);
                    state_d  = STAGED;
                end
            end
            STAGED: begin
                // a write always wins over read-abort or timeout
                if (we_i) begin
                    if (ctrl_t'(wd_i) == staged_q) begin
                        state_d = COMMIT;
                    end else begin
                        uerr_d   = 1'b1;
                        staged_d = q_q;
                        state_d  = IDLE;
                    end
                end else if (re_i || expired) begin
                    staged_d = q_q;
                    state_d  = IDLE;
                end
            end
            COMMIT: begin
                q_d     = staged_q;
                state_d = IDLE;
            end
            default: begin
                staged_d = q_q;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            staged_q <= RESVAL;
            q_q      <= RESVAL;
            uerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            staged_q <= staged_d;
            q_q      <= q_d;
            uerr_q   <= uerr_d;
        end
    end

    assign ready_o      = (state_q != COMMIT);
    assign busy_o       = (state_q == STAGED);
    assign qs_o         = staged_q;
    assign q_o          = q_q;
    assign update_err_o = uerr_q;

`ifdef CTRL_SHADOW_STORAGE_CHK_EN
    logic [4:0] q_inv_q, q_inv_d;
    logic       serr_q, serr_d;

    always_comb begin
        q_inv_d = q_inv_q;
        if (state_q == COMMIT) begin
            q_inv_d = ~staged_q;
        end
        serr_d = serr_q | (q_inv_q != ~q_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_inv_q <= ~RESVAL;
            serr_q  <= 1'b0;
        end else begin
            q_inv_q <= q_inv_d;
            serr_q  <= serr_d;
        end
    end

    assign storage_err_o = serr_q;
`else
    assign storage_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_shadow_wr.sv
// Scoreboard bench for ctrl_shadow_wr: random and directed writes
// against a phase-level reference model.
module tb_ctrl_shadow_wr;

    localparam int TO = 16;
    localparam logic [4:0] RV = 5'd24;

    typedef struct packed {
        logic [4:0] q;
        logic [4:0] qs;
        logic       rdy;
        logic       bsy;
        logic       uerr;
        logic       serr;
    } exp_t;

    logic       clk;
    logic       rst_ni;
    logic       we_i;
    logic [4:0] wd_i;
    logic       re_i;
    logic       ready_o;
    logic       busy_o;
    logic [4:0] qs_o;
    logic [4:0] q_o;
    logic       update_err_o;
    logic       storage_err_o;

    int tests = 0;
    int fails = 0;

    exp_t sb[$];

    // reference model state
    bit       m_pend;
    bit       m_cpend;
    bit       m_err;
    bit       m_serr;
    int       m_age;
    bit [4:0] m_stg;
    bit [4:0] m_com;

    ctrl_shadow_wr #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .we_i         (we_i),
        .wd_i         (wd_i),
        .re_i         (re_i),
        .ready_o      (ready_o),
        .busy_o       (busy_o),
        .qs_o         (qs_o),
        .q_o          (q_o),
        .update_err_o (update_err_o),
        .storage_err_o(storage_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm,
                                logic [31:0] act,
                                logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_pend  = 0;
        m_cpend = 0;
        m_err   = 0;
        m_serr  = 0;
        m_age   = 0;
        m_stg   = RV;
        m_com   = RV;
    endfunction

    task automatic check_reset_now(string tag);
        chk({tag, "_q"}, 32'(q_o), 32'(RV));
        chk({tag, "_qs"}, 32'(qs_o), 32'(RV));
        chk({tag, "_rdy"}, 32'(ready_o), 1);
        chk({tag, "_bsy"}, 32'(busy_o), 0);
        chk({tag, "_uerr"}, 32'(update_err_o), 0);
        chk({tag, "_serr"}, 32'(storage_err_o), 0);
    endtask

    // Called at a negedge: drive, predict the post-edge outputs, wait.
    task automatic step(bit we, bit [4:0] wd, bit re);
        exp_t e;
        we_i = we;
        wd_i = wd;
        re_i = re;
        m_err = 0;
        if (m_cpend) begin
            m_com   = m_stg;
            m_cpend = 0;
        end else if (!m_pend) begin
            if (we) begin
                m_pend = 1;
                m_stg  = wd;
                m_age  = 0;
            end
        end else begin
            m_age++;
            if (we) begin
                m_pend = 0;
                if (wd == m_stg) begin
                    m_cpend = 1;
                end else begin
                    m_err = 1;
                    m_stg = m_com;
                end
            end else if (re || m_age >= TO) begin
                m_pend = 0;
                m_stg  = m_com;
            end
        end
        e.q    = m_com;
        e.qs   = m_stg;
        e.rdy  = !m_cpend;
        e.bsy  = m_pend;
        e.uerr = m_err;
        e.serr = m_serr;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 5'd0, 0);
    endtask

    // monitor: compare every cycle that has a predicted response
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q_o", 32'(q_o), 32'(e.q));
                chk("qs_o", 32'(qs_o), 32'(e.qs));
                chk("ready_o", 32'(ready_o), 32'(e.rdy));
                chk("busy_o", 32'(busy_o), 32'(e.bsy));
                chk("update_err_o", 32'(update_err_o), 32'(e.uerr));
                chk("storage_err_o", 32'(storage_err_o), 32'(e.serr));
            end
        end
    end

    initial begin
        bit [4:0] wd;
        bit       we;
        bit       re;
        rst_ni = 1'b0;
        we_i   = 1'b0;
        wd_i   = 5'd0;
        re_i   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check_reset_now("init");
        @(negedge clk);

        // mismatch on second write
        step(1, 5'h05, 0);
        step(1, 5'h06, 0);
        idle(2);

        // phase timeout, then a fresh first write
        step(1, 5'h05, 0);
        idle(TO);
        step(1, 5'h05, 0);
        idle(1);

        // read abort, then new phase and async reset mid-phase
        step(0, 5'h00, 1);
        step(1, 5'h05, 0);
        idle(2);
        #2 rst_ni = 1'b0;
        #1;
        check_reset_now("midrst");
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // clean commit, then simultaneous write and read
        step(1, 5'h05, 0);
        step(1, 5'h05, 0);
        step(1, 5'h1f, 0);
        idle(2);
        step(1, 5'h09, 1);
        step(1, 5'h09, 1);
        idle(2);

`ifdef CTRL_SHADOW_STORAGE_CHK_EN
        force dut.q_inv_q = ~q_o ^ 5'b00001;
        m_serr = 1;
        step(0, 5'h00, 0);
        release dut.q_inv_q;
        idle(3);
        step(1, 5'h02, 0);
        step(1, 5'h02, 0);
        idle(2);
        #2 rst_ni = 1'b0;
        #1;
        check_reset_now("serrrst");
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
`endif

        // dense random traffic
        for (int i = 0; i < 2000; i++) begin
            we = ($urandom_range(0, 99) < 50);
            re = ($urandom_range(0, 99) < 20);
            if (m_pend && $urandom_range(0, 99) < 60)
                wd = m_stg;
            else
                wd = 5'($urandom);
            step(we, wd, re);
        end

        // sparse traffic so phases reach the timeout
        for (int i = 0; i < 1500; i++) begin
            we = ($urandom_range(0, 99) < 5);
            re = ($urandom_range(0, 99) < 2);
            if (m_pend && $urandom_range(0, 99) < 70)
                wd = m_stg;
            else
                wd = 5'($urandom);
            step(we, wd, re);
        end

        idle(2);
        for (int i = 0; i < 5 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() > 0)
            chk("drain", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
